// File: rtl/reg_read_port.sv
// Register file with a single-cycle write port and a handshaked read port.
// Read results queue in a 2-entry response buffer so a stalled consumer never loses data.
module reg_read_port #(
   parameter int WIDTH  = 8,
   parameter int NREGS  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_rsp_valid,
   input  logic              rd_rsp_ready,
   output logic [WIDTH-1:0]  rd_data
);

   localparam logic [ADDR_W:0] NREGS_EXT = (ADDR_W+1)'(NREGS);

   logic [WIDTH-1:0] r_regs [NREGS];
   logic [WIDTH-1:0] r_buf [2];
   logic             r_wrPtr;
   logic             r_rdPtr;
   logic [1:0]       r_count;

   logic             w_wrHit;
   logic             w_rdInRange;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_capData;

   assign w_wrHit     = wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < NREGS_EXT);
   assign w_rdInRange = (rd_addr != '0) && ({1'b0, rd_addr} < NREGS_EXT);

   assign rd_req_ready = (r_count < 2'd2);
   assign rd_rsp_valid = (r_count != 2'd0);
   assign rd_data      = rd_rsp_valid ? r_buf[r_rdPtr] : '0;

   assign w_push = rd_req_valid && rd_req_ready;
   assign w_pop  = rd_rsp_valid && rd_rsp_ready;

   // Write-first: a same-cycle write to the read address is forwarded into the buffer.
   always_comb begin
      w_capData = '0;
      if (w_rdInRange) begin
         if (wr_en && (wr_addr == rd_addr)) begin
            w_capData = wr_data;
         end else begin
            w_capData = r_regs[rd_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wrHit) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf[0] <= '0;
         r_buf[1] <= '0;
         r_wrPtr  <= 1'b0;
         r_rdPtr  <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_buf[r_wrPtr] <= w_capData;
            r_wrPtr        <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: vector table plus hand-written back-pressure
// and reset sequences, with responses checked in order against a scoreboard queue.
module tb_reg_read_port;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_req_valid;
   logic       rd_req_ready;
   logic [2:0] rd_addr;
   logic       rd_rsp_valid;
   logic       rd_rsp_ready;
   logic [7:0] rd_data;

   typedef struct {
      logic       we;
      logic [2:0] wa;
      logic [7:0] wd;
      logic       rv;
      logic [2:0] ra;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs [19];
   logic [7:0] scoreQ [$];
   logic [7:0] curExp;
   int         nChecks = 0;
   int         nFails  = 0;

   reg_read_port #(.WIDTH(8), .NREGS(8), .ADDR_W(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_addr      (rd_addr),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .rd_data      (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rstN, input logic we, input logic [2:0] wa,
                                input logic [7:0] wd, input logic rv, input logic [2:0] ra,
                                input logic rr, input logic [7:0] exp);
      @(posedge clk);
      #2;
      rst_n        = rstN;
      wr_en        = we;
      wr_addr      = wa;
      wr_data      = wd;
      rd_req_valid = rv;
      rd_addr      = ra;
      rd_rsp_ready = rr;
      curExp       = exp;
   endtask

   task automatic drainQueue();
      int n = 0;
      while (scoreQ.size() != 0 && n < 20) begin
         applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00);
         n++;
      end
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00);
      checkOutput("drain_empty", 8'(scoreQ.size()), 8'd0);
   endtask

   // Inputs settle 2 time units after the rising edge, so the falling edge sees a stable
   // picture of what the next rising edge will accept and pop.
   always @(negedge clk) begin
      if (!rst_n) begin
         scoreQ.delete();
      end else begin
         if (rd_rsp_valid && rd_rsp_ready) begin
            if (scoreQ.size() == 0) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL unexpected_rsp: got %h, expected no response at %0t", rd_data, $time);
            end else begin
               checkOutput("rsp_data", rd_data, scoreQ.pop_front());
            end
         end
         if (rd_req_valid && rd_req_ready) begin
            scoreQ.push_back(curExp);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h00};
      vecs[1]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 8'h00};
      vecs[2]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'h00};
      vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h00};
      vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h00};
      vecs[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h00};
      vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h00};
      vecs[7]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00};
      vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 8'hA5};
      vecs[9]  = '{1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00};
      vecs[10] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h00};
      vecs[11] = '{1'b1, 3'd5, 8'h3C, 1'b1, 3'd5, 8'h3C};
      vecs[12] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h3C};
      vecs[13] = '{1'b1, 3'd1, 8'h11, 1'b0, 3'd0, 8'h00};
      vecs[14] = '{1'b1, 3'd2, 8'h22, 1'b0, 3'd0, 8'h00};
      vecs[15] = '{1'b1, 3'd3, 8'h33, 1'b1, 3'd1, 8'h11};
      vecs[16] = '{1'b1, 3'd6, 8'h66, 1'b1, 3'd3, 8'h33};
      vecs[17] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h66};
      vecs[18] = '{1'b1, 3'd6, 8'h77, 1'b1, 3'd6, 8'h77};

      rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00;
      rd_req_valid = 1'b0; rd_addr = 3'd0; rd_rsp_ready = 1'b1; curExp = 8'h00;

      $display("[TB] reset");
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00);
      checkOutput("reset_rsp_valid", 8'(rd_rsp_valid), 8'd0);
      checkOutput("reset_req_ready", 8'(rd_req_ready), 8'd1);
      checkOutput("reset_rd_data", rd_data, 8'h00);

      $display("[TB] vector table");
      for (int i = 0; i < 19; i++) begin
         applyStimulus(1'b1, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra, 1'b1, vecs[i].exp);
      end
      drainQueue();

      $display("[TB] back-pressure");
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0, 8'h11);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 8'h22);
      checkOutput("bp_ready_cnt1", 8'(rd_req_ready), 8'd1);
      checkOutput("bp_valid_cnt1", 8'(rd_rsp_valid), 8'd1);
      checkOutput("bp_data_cnt1", rd_data, 8'h11);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 8'h33);
         checkOutput("bp_ready_full", 8'(rd_req_ready), 8'd0);
         checkOutput("bp_data_hold", rd_data, 8'h11);
      end
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h33);
      checkOutput("bp_ready_still_low", 8'(rd_req_ready), 8'd0);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h33);
      checkOutput("bp_ready_restored", 8'(rd_req_ready), 8'd1);
      checkOutput("bp_data_second", rd_data, 8'h22);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00);
      checkOutput("bp_data_third", rd_data, 8'h33);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00);
      checkOutput("bp_valid_empty", 8'(rd_rsp_valid), 8'd0);
      checkOutput("bp_data_empty", rd_data, 8'h00);
      drainQueue();

      $display("[TB] streaming push/pop");
      for (int i = 0; i < 4; i++) begin
         logic [7:0] e;
         e = (i == 3) ? 8'h00 : 8'(8'h11 * (i + 1));
         applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i + 1), 1'b1, e);
         checkOutput("stream_ready", 8'(rd_req_ready), 8'd1);
         if (i > 0) begin
            checkOutput("stream_valid", 8'(rd_rsp_valid), 8'd1);
         end
      end
      drainQueue();

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b0, 8'h11);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 8'h22);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00);
      checkOutput("midrst_full", 8'(rd_req_ready), 8'd0);
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h11);
      applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b1, 8'h00);
      checkOutput("midrst_valid", 8'(rd_rsp_valid), 8'd0);
      checkOutput("midrst_ready", 8'(rd_req_ready), 8'd1);
      checkOutput("midrst_data", rd_data, 8'h00);
      for (int i = 1; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 1'b1, 8'h00);
      end
      drainQueue();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/reg_read_port.md
Name: reg_read_port

Overview:
Register-file block for the CPU: a WIDTH-bit register array with one single-cycle write port and a handshaked read port that returns data through a 2-entry response buffer. It gives the datapath a read path with back-pressure, so a stalled consumer never loses a read result. Register 0 is hardwired to zero.

Parameters:
WIDTH, 8, data width of each register
NREGS, 8, number of registers (2..2**ADDR_W)
ADDR_W, 3, address width

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
rd_req_valid  input  1  read request present
rd_req_ready  output  1  read request can be accepted
rd_addr  input  ADDR_W  read address, qualified by rd_req_valid
rd_rsp_valid  output  1  response data present
rd_rsp_ready  input  1  consumer accepts response
rd_data  output  WIDTH  response data (head of response buffer)

Behaviour:
- Reset (rst_n=0 at a clock edge): all registers cleared to 0; response buffer emptied.
  - After that edge: rd_rsp_valid=0, rd_data=0, rd_req_ready=1.
  - Reset mid-operation discards buffered responses; no response is produced for any in-flight request.
- Write:
  - When wr_en=1, wr_addr is in 1..NREGS-1 and rst_n=1, the register takes wr_data at the edge.
  - Writes to address 0 or to an address >= NREGS are ignored.
- Read accept: a request is accepted at an edge where rd_req_valid && rd_req_ready. rd_req_ready = (count < 2) and depends only on registered state.
- Read data capture happens at the accept edge. The value pushed into the buffer is:
  - 0 if rd_addr==0 or rd_addr>=NREGS.
  - else wr_data if wr_en=1 and wr_addr==rd_addr in the same cycle (write-first bypass).
  - else the current register contents.
- Latency: if the buffer was empty, rd_rsp_valid=1 on the cycle after acceptance with the captured data. With back-pressure, responses leave in request order.
- Response handshake:
  - Pop on an edge where rd_rsp_valid && rd_rsp_ready.
  - While rd_rsp_valid=1 and rd_rsp_ready=0, rd_data and rd_rsp_valid stay stable.
  - A later write to the same register does not alter already-captured data.
- Buffer count 0..2:
  - push only: +1; pop only: -1; push and pop in the same cycle: unchanged.
  - Push is impossible at count=2, because ready is low.
  - Pop at count=2 restores rd_req_ready=1 on the next cycle. There is no same-cycle ready pass-through.
- Buffer pointers are 1 bit each and wrap 1->0.
- rd_data=0 whenever rd_rsp_valid=0.
- Write and read to different addresses in the same cycle are independent. The written value is visible to reads accepted in later cycles.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, then release -> rd_rsp_valid=0, rd_req_ready=1, rd_data=0. Reads of r1..r7 return 0x00.
2. Write then read: write r3=0xA5; next cycle request rd_addr=3 with rd_rsp_ready=1 -> rd_rsp_valid=1 one cycle later, rd_data=0xA5. Write r0=0xFF, then read r0 -> 0x00.
3. Bypass: in the same cycle, wr_en=1, wr_addr=5, wr_data=0x3C and a read request for addr 5 -> response 0x3C.
4. Back-pressure: hold rd_rsp_ready=0 and issue reads of r1=0x11, r2=0x22, r3=0x33.
   - The first two are accepted; rd_req_ready=0 from the cycle after the second accept, so the third waits.
   - rd_data holds 0x11 while stalled.
   - Raise rd_rsp_ready -> outputs in order 0x11, 0x22, 0x33, with no loss or duplication.
5. Simultaneous push/pop at count=1: request a read every cycle with rd_rsp_ready=1 -> count stays 1, one response per cycle, rd_req_ready stays 1.
6. Reset mid-operation: buffer holds 2 responses, assert rst_n=0 for one cycle -> rd_rsp_valid=0 next cycle, all registers read back 0x00, no stale data emitted.
